// File: rtl/bus_arbiter2_pkg.sv
// bus_arbiter2_pkg: shared FSM states, op encoding, master indices and grant selection for bus_arbiter2.
package bus_arbiter2_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_e;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
  function automatic logic pick(input logic v0, input logic v1, input logic last, input logic rr);
    return (v0 && v1) ? (rr ? ~last : M0) : v1;
  endfunction
endpackage

// File: rtl/bus_arbiter2_slot.sv
// arb_req_slot: per-master request latch; ports: master we/rd/a/d in, done/spo from arbiter, held a/d/op, valid, spo, ready out.
module arb_req_slot
  import bus_arbiter2_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic          rd_i,
  input  logic [AW-1:0] a_i,
  input  logic [DW-1:0] d_i,
  input  logic          done_i,
  input  logic [DW-1:0] spo_i,
  output logic          valid_o,
  output logic [AW-1:0] a_o,
  output logic [DW-1:0] d_o,
  output op_e           op_o,
  output logic [DW-1:0] spo_o,
  output logic          ready_o
);
  logic          ready_q, ready_d, acc;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] d_q, d_d, spo_q, spo_d;
  op_e           op_q, op_d;
  always_comb begin
    acc     = ready_q && (we_i || rd_i);
    ready_d = acc ? 1'b0 : done_i ? 1'b1 : ready_q;
    a_d     = acc ? a_i : a_q;
    d_d     = acc ? d_i : d_q;
    op_d    = acc ? (we_i ? OP_WR : OP_RD) : op_q;
    spo_d   = (done_i && op_q == OP_RD) ? spo_i : spo_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b1;
      a_q     <= '0;
      d_q     <= '0;
      op_q    <= OP_RD;
      spo_q   <= '0;
    end else begin
      ready_q <= ready_d;
      a_q     <= a_d;
      d_q     <= d_d;
      op_q    <= op_d;
      spo_q   <= spo_d;
    end
  end
  assign valid_o = ~ready_q;
  assign a_o     = a_q;
  assign d_o     = d_q;
  assign op_o    = op_q;
  assign spo_o   = spo_q;
  assign ready_o = ready_q;
endmodule

// File: rtl/bus_arbiter2.sv
// bus_arbiter2: two-master to one-target bus arbiter.
// Ports: clk, rst (sync, active-high); per master mN_a/mN_d/mN_we/mN_rd in, mN_spo/mN_ready out;
// downstream a/d/we/rd out, spo/ready in. Define ARB_ROUND_ROBIN_EN for alternating grant,
// otherwise m0 has fixed priority.
module bus_arbiter2
  import bus_arbiter2_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_a,
  input  logic [DW-1:0] m0_d,
  input  logic          m0_we,
  input  logic          m0_rd,
  output logic [DW-1:0] m0_spo,
  output logic          m0_ready,
  input  logic [AW-1:0] m1_a,
  input  logic [DW-1:0] m1_d,
  input  logic          m1_we,
  input  logic          m1_rd,
  output logic [DW-1:0] m1_spo,
  output logic          m1_ready,
  output logic [AW-1:0] a,
  output logic [DW-1:0] d,
  output logic          we,
  output logic          rd,
  input  logic [DW-1:0] spo,
  input  logic          ready
);
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif
  logic          s0_valid, s1_valid;
  logic [AW-1:0] s0_a, s1_a;
  logic [DW-1:0] s0_d, s1_d;
  op_e           s0_op, s1_op, win_op;
  state_e        state_q, state_d;
  logic          gnt_q, gnt_d, last_q, last_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] d_q, d_d;
  logic          issue, win, done;
  arb_req_slot #(.AW(AW), .DW(DW)) u_slot0 (
    .clk(clk), .rst(rst), .we_i(m0_we), .rd_i(m0_rd), .a_i(m0_a), .d_i(m0_d),
    .done_i(done && gnt_q == M0), .spo_i(spo), .valid_o(s0_valid), .a_o(s0_a),
    .d_o(s0_d), .op_o(s0_op), .spo_o(m0_spo), .ready_o(m0_ready)
  );
  arb_req_slot #(.AW(AW), .DW(DW)) u_slot1 (
    .clk(clk), .rst(rst), .we_i(m1_we), .rd_i(m1_rd), .a_i(m1_a), .d_i(m1_d),
    .done_i(done && gnt_q == M1), .spo_i(spo), .valid_o(s1_valid), .a_o(s1_a),
    .d_o(s1_d), .op_o(s1_op), .spo_o(m1_spo), .ready_o(m1_ready)
  );
  // The issue cycle is the IDLE exit: a/d come straight from the winning slot, then a_q/d_q hold them.
  always_comb begin
    issue   = state_q == ST_IDLE && (s0_valid || s1_valid);
    win     = pick(s0_valid, s1_valid, last_q, RR);
    win_op  = win ? s1_op : s0_op;
    a       = issue ? (win ? s1_a : s0_a) : a_q;
    d       = issue ? (win ? s1_d : s0_d) : d_q;
    we      = issue && win_op == OP_WR;
    rd      = issue && win_op == OP_RD;
    done    = state_q == ST_WAIT && ready;
    state_d = issue ? ST_WAIT : done ? ST_RESP : (state_q == ST_RESP) ? ST_IDLE : state_q;
    gnt_d   = issue ? win : gnt_q;
    last_d  = done ? gnt_q : last_q;
    a_d     = a;
    d_d     = d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= M0;
      last_q  <= M0;
      a_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      a_q     <= a_d;
      d_q     <= d_d;
    end
  end
endmodule
